// File: rtl/imem_rr_arbiter.sv
// Round-robin arbiter between the CPU instruction-fetch ports and one shared synchronous ROM.
// Requesters asking for the winner's word in the same cycle ride on the same access.
module imem_rr_arbiter #(
    parameter int nCPUs  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [nCPUs-1:0]               req,
    input  logic [nCPUs-1:0][ADDR_W-1:0]   addr,
    output logic [nCPUs-1:0]               gnt,
    output logic [nCPUs-1:0]               rvalid,
    output logic [DATA_W-1:0]              rdata,
    output logic                           mem_en,
    output logic [MEM_AW-1:0]              mem_addr,
    input  logic [DATA_W-1:0]              mem_rdata
);

    localparam int PTR_W = (nCPUs > 1) ? $clog2(nCPUs) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(nCPUs - 1);

    logic [PTR_W-1:0]  ptr_r;
    logic [nCPUs-1:0]  rvalid_r;
    logic [MEM_AW-1:0] lastAddr_r;
    logic [PTR_W-1:0]  win_s;
    logic [PTR_W-1:0]  cand_s;
    logic [PTR_W-1:0]  nextPtr_s;
    logic              found_s;
    logic [MEM_AW-1:0] winWord_s;
    logic [nCPUs-1:0]  gnt_s;
    logic              unusedAddr_s;

    // Byte-offset bits and bits above the ROM word index are deliberately dropped.
    assign unusedAddr_s = ^addr;

    // Scan requesters starting at the pointer; first active one wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = ptr_r;
        cand_s  = ptr_r;
        for (int k = 0; k < nCPUs; k++) begin
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
            cand_s = (cand_s == LAST_PTR) ? {PTR_W{1'b0}} : cand_s + PTR_W'(1);
        end
    end

    assign winWord_s = addr[win_s][MEM_AW+1:2];
    assign nextPtr_s = (win_s == LAST_PTR) ? {PTR_W{1'b0}} : win_s + PTR_W'(1);

    // Grant the winner plus every requester fetching the same ROM word; nothing while in reset.
    always_comb begin
        gnt_s = {nCPUs{1'b0}};
        for (int j = 0; j < nCPUs; j++) begin
            if (rst && found_s && req[j] && (addr[j][MEM_AW+1:2] == winWord_s)) begin
                gnt_s[j] = 1'b1;
            end else begin
                gnt_s[j] = 1'b0;
            end
        end
    end

    // Pointer rotation past the winner, response valid pipeline and idle address hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r      <= {PTR_W{1'b0}};
            rvalid_r   <= {nCPUs{1'b0}};
            lastAddr_r <= {MEM_AW{1'b0}};
        end else begin
            rvalid_r <= gnt_s;
            if (|gnt_s) begin
                ptr_r      <= nextPtr_s;
                lastAddr_r <= winWord_s;
            end
        end
    end

    assign gnt      = gnt_s;
    assign mem_en   = |gnt_s;
    assign mem_addr = (|gnt_s) ? winWord_s : lastAddr_r;
    assign rvalid   = rvalid_r;
    assign rdata    = mem_rdata;

endmodule

// File: doc/imem_rr_arbiter.md
Name: imem_rr_arbiter

Overview:
- Sits between the nCPUs instruction-fetch ports of the single-cycle CPU cluster and one shared synchronous instruction ROM.
- Each cycle it picks one fetch address by round-robin and drives it to the ROM.
- Any other requester asking for the same word in that cycle is served by the same access (merge).
- Returns the instruction word one cycle later with a per-CPU valid; requesters that lost arbitration are stalled.

Parameters:
- nCPUs, 3, number of fetch ports (1..8).
- ADDR_W, 32, byte address width of each fetch port.
- DATA_W, 32, instruction word width.
- MEM_AW, 6, ROM word-address width; ROM depth is 2**MEM_AW words.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- req  input  nCPUs  per-CPU fetch request.
- addr  input  nCPUs x ADDR_W  per-CPU byte fetch address (packed, CPU i at [i]).
- gnt  output  nCPUs  per-CPU grant, combinational, same cycle as req.
- rvalid  output  nCPUs  per-CPU read-data valid, registered, one cycle after gnt.
- rdata  output  DATA_W  instruction word, shared by all CPUs; qualified by rvalid[i].
- mem_en  output  1  ROM read enable.
- mem_addr  output  MEM_AW  ROM word address = addr[winner][MEM_AW+1:2].
- mem_rdata  input  DATA_W  ROM data, valid the cycle after mem_en.

Behaviour:
- State: round-robin pointer ptr (0..nCPUs-1); rvalid register (nCPUs bits).
- Reset (rst=0, asynchronous): ptr=0, rvalid=0.
  - gnt and mem_en are forced to 0 while rst=0, regardless of req.
- Winner selection, combinational:
  - Scan i = ptr, ptr+1, ... modulo nCPUs.
  - Winner w = first i with req[i]=1.
  - No req set: no winner, mem_en=0, gnt=0, mem_addr holds its last value (don't care).
- Merge rule:
  - gnt[j]=1 for every j with req[j]=1 and addr[j][MEM_AW+1:2] == addr[w][MEM_AW+1:2].
  - This includes w itself. Byte offset bits [1:0] and bits above MEM_AW+1 are ignored.
- mem_en = |gnt; mem_addr from w.
- Pointer update on posedge clk:
  - If any grant, ptr <= (w+1) mod nCPUs.
  - Merged non-winners do not move the pointer.
  - If no grant, ptr holds.
- Response: rvalid <= gnt on every posedge. rdata = mem_rdata passes through combinationally; valid when any rvalid bit is 1.
- Latency: exactly 1 cycle from gnt to rvalid. Throughput is one ROM access per cycle.
- Requester rule:
  - Hold req=1 and addr stable until gnt=1.
  - Dropping req before gnt is allowed (withdrawn fetch) and causes no side effect.
  - A CPU may re-request in the cycle it receives rvalid.
- Fairness: a CPU that holds req is granted within nCPUs cycles.
- Single CPU requesting continuously is granted every cycle.
- Reset asserted mid-operation: a pending rvalid is cleared immediately; no stale rvalid appears after rst deasserts.
- Out-of-range addresses (above ROM depth) wrap via truncation to MEM_AW bits. No error is reported.
- No combinational path from rdata/mem_rdata to gnt.

Test Plan:
1. Reset and idle:
   - Hold rst=0 with req=3'b111.
   - Expect gnt=0, mem_en=0, rvalid=0.
   - Release rst with req=0: outputs stay 0 and ptr=0.
2. Round-robin rotation:
   - req=3'b111, addr = 0x00 / 0x04 / 0x30, held.
   - Expect gnt sequence 001, 010, 100, 001 on consecutive cycles.
   - mem_addr sequence 0, 1, 12, 0.
   - rvalid follows gnt one cycle later, and rdata equals the ROM word at each address.
3. Merge:
   - req=3'b011, both addr=0x10; CPU2 idle; ptr=0.
   - Expect gnt=3'b011, a single mem_en, mem_addr=4.
   - Next cycle rvalid=3'b011; ptr becomes 1.
4. Byte-offset merge and mismatch:
   - addr0=0x12, addr1=0x10, addr2=0x14, req=3'b111, ptr=0.
   - Expect gnt=3'b011, and CPU2 is granted next cycle.
5. Starvation bound:
   - CPU0 requests every cycle; CPU2 raises req with a distinct address.
   - Expect gnt[2]=1 within 3 cycles.
6. Mid-flight reset:
   - Assert rst=0 asynchronously between the posedge that sets rvalid=3'b001 and the next one.
   - Expect rvalid=0 immediately; after release the first grant goes to CPU0 (ptr=0).
